// File: rtl/lustre_seq_compare_pkg.sv
// Shared definitions for the serial comparator: op codes, FSM state encoding,
// and the mapping from (lt, eq) to the selected comparison result.
package lustre_seq_compare_pkg;

  localparam logic [2:0] LUSTRE_CMP_EQ = 3'd0;
  localparam logic [2:0] LUSTRE_CMP_NE = 3'd1;
  localparam logic [2:0] LUSTRE_CMP_LT = 3'd2;
  localparam logic [2:0] LUSTRE_CMP_LE = 3'd3;
  localparam logic [2:0] LUSTRE_CMP_GT = 3'd4;
  localparam logic [2:0] LUSTRE_CMP_GE = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Reserved op codes 6 and 7 deliberately yield 0.
  function automatic logic cmp_result(input logic [2:0] op, input logic lt, input logic eq);
    logic r;
    r = 1'b0;
    case (op)
      LUSTRE_CMP_EQ: r = eq;
      LUSTRE_CMP_NE: r = ~eq;
      LUSTRE_CMP_LT: r = lt;
      LUSTRE_CMP_LE: r = lt | eq;
      LUSTRE_CMP_GT: r = ~(lt | eq);
      LUSTRE_CMP_GE: r = ~lt;
      default:       r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lustre_seq_compare_adder.sv
// Chunk adder for the serial comparator: sum, carry-out and signed overflow
// of a_i + b_i + carry_i.
module internal_lustre_adder #(
  parameter int N = 4
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  input  logic         carry_i,
  output logic [N-1:0] sum_o,
  output logic         flag_C_o,
  output logic         flag_V_o
);

  logic [N:0] full;

  assign full     = {1'b0, a_i} + {1'b0, b_i} + (N+1)'(carry_i);
  assign sum_o    = full[N-1:0];
  assign flag_C_o = full[N];
  // The carry into the MSB is recovered from the MSB sum bit, which also covers N=1.
  assign flag_V_o = full[N] ^ (a_i[N-1] ^ b_i[N-1] ^ full[N-1]);

endmodule

// File: rtl/lustre_seq_compare.sv
// Multi-cycle comparator: lhs - rhs evaluated CHUNK bits per cycle, LSB first.
// Define LUSTRE_SEQ_COMPARE_FLAGS_EN to expose the Z/N/C/V flag outputs.
module lustre_seq_compare
  import lustre_seq_compare_pkg::*;
#(
  parameter int N     = 8,
  parameter int CHUNK = 4
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] lhs,
  input  logic [N-1:0] rhs,
  input  logic [2:0]   op,
  input  logic         is_signed,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         res
`ifdef LUSTRE_SEQ_COMPARE_FLAGS_EN
  ,
  output logic         flag_Z,
  output logic         flag_N,
  output logic         flag_C,
  output logic         flag_V
`endif
);

  localparam int STEPS = N / CHUNK;
  localparam int IDX_W = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(STEPS - 1);

  generate
    if (N < 1 || CHUNK < 1 || CHUNK > N || (N % CHUNK) != 0) begin : g_bad_params
      $error("lustre_seq_compare: CHUNK must divide N with 1 <= CHUNK <= N");
    end
  endgenerate

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [N-1:0]     lhs_q;
  logic [N-1:0]     rhsInv_q;
  logic [2:0]       op_q;
  logic             signed_q;
  logic             carry_q;
  logic             z_q;
  logic             res_q;
  logic             outValid_q;

  logic [CHUNK-1:0] chunkA;
  logic [CHUNK-1:0] chunkB;
  logic [CHUNK-1:0] chunkSum;
  logic             chunkC;
  logic             chunkV;
  logic             z_d;
  logic             lt_d;
  logic             res_d;
  logic             accept;
  logic             lastStep;

  assign chunkA = lhs_q[idx_q*CHUNK +: CHUNK];
  assign chunkB = rhsInv_q[idx_q*CHUNK +: CHUNK];

  internal_lustre_adder #(.N(CHUNK)) u_adder (
    .a_i      (chunkA),
    .b_i      (chunkB),
    .carry_i  (carry_q),
    .sum_o    (chunkSum),
    .flag_C_o (chunkC),
    .flag_V_o (chunkV)
  );

  // Result is only meaningful on the last chunk, where the MSB and final carry live.
  assign z_d      = z_q & (chunkSum == '0);
  assign lt_d     = signed_q ? (chunkSum[CHUNK-1] ^ chunkV) : ~chunkC;
  assign res_d    = cmp_result(op_q, lt_d, z_d);
  assign lastStep = (state_q == ST_RUN) && (idx_q == LAST_IDX);

  assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = outValid_q;
  assign res       = res_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      lhs_q      <= '0;
      rhsInv_q   <= '0;
      op_q       <= '0;
      signed_q   <= 1'b0;
      carry_q    <= 1'b1;
      z_q        <= 1'b1;
      res_q      <= 1'b0;
      outValid_q <= 1'b0;
    end else if (accept) begin
      state_q    <= ST_RUN;
      idx_q      <= '0;
      lhs_q      <= lhs;
      rhsInv_q   <= ~rhs;
      op_q       <= op;
      signed_q   <= is_signed;
      carry_q    <= 1'b1;
      z_q        <= 1'b1;
      outValid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_RUN: begin
          carry_q <= chunkC;
          z_q     <= z_d;
          if (lastStep) begin
            res_q      <= res_d;
            outValid_q <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            outValid_q <= 1'b0;
            state_q    <= ST_IDLE;
          end
        end
        ST_IDLE: ;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef LUSTRE_SEQ_COMPARE_FLAGS_EN
  logic flagZ_q;
  logic flagN_q;
  logic flagC_q;
  logic flagV_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      flagZ_q <= 1'b0;
      flagN_q <= 1'b0;
      flagC_q <= 1'b0;
      flagV_q <= 1'b0;
    end else if (lastStep && !accept) begin
      flagZ_q <= z_d;
      flagN_q <= chunkSum[CHUNK-1];
      flagC_q <= chunkC;
      flagV_q <= chunkV;
    end
  end

  assign flag_Z = flagZ_q;
  assign flag_N = flagN_q;
  assign flag_C = flagC_q;
  assign flag_V = flagV_q;
`endif

endmodule

// File: tb/tb_lustre_seq_compare.sv
// Directed bench for lustre_seq_compare: CHUNK=4, 8 and 1 builds run side by side.
// Flag checks are included when LUSTRE_SEQ_COMPARE_FLAGS_EN is defined.
module tb_lustre_seq_compare;

  logic       clock;
  logic       reset_n;
  logic       in_valid;
  logic [7:0] lhs;
  logic [7:0] rhs;
  logic [2:0] op;
  logic       is_signed;
  logic       out_ready;

  logic inReady4, inReady8, inReady1;
  logic outValid4, outValid8, outValid1;
  logic res4, res8, res1;

  int errors;
  int checks;

`ifdef LUSTRE_SEQ_COMPARE_FLAGS_EN
  logic flagZ, flagN, flagC, flagV;
  logic [3:0] flags8Unused, flags1Unused;
`endif

  lustre_seq_compare #(.N(8), .CHUNK(4)) dut4 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(inReady4),
    .lhs(lhs), .rhs(rhs), .op(op), .is_signed(is_signed),
    .out_valid(outValid4), .out_ready(out_ready), .res(res4)
`ifdef LUSTRE_SEQ_COMPARE_FLAGS_EN
    , .flag_Z(flagZ), .flag_N(flagN), .flag_C(flagC), .flag_V(flagV)
`endif
  );

  lustre_seq_compare #(.N(8), .CHUNK(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(inReady8),
    .lhs(lhs), .rhs(rhs), .op(op), .is_signed(is_signed),
    .out_valid(outValid8), .out_ready(out_ready), .res(res8)
`ifdef LUSTRE_SEQ_COMPARE_FLAGS_EN
    , .flag_Z(flags8Unused[0]), .flag_N(flags8Unused[1]),
    .flag_C(flags8Unused[2]), .flag_V(flags8Unused[3])
`endif
  );

  lustre_seq_compare #(.N(8), .CHUNK(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(inReady1),
    .lhs(lhs), .rhs(rhs), .op(op), .is_signed(is_signed),
    .out_valid(outValid1), .out_ready(out_ready), .res(res1)
`ifdef LUSTRE_SEQ_COMPARE_FLAGS_EN
    , .flag_Z(flags1Unused[0]), .flag_N(flags1Unused[1]),
    .flag_C(flags1Unused[2]), .flag_V(flags1Unused[3])
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] op;
    logic       sgn;
    logic [7:0] a;
    logic [7:0] b;
    logic       exp;
  } vec_t;

  vec_t vecs[16];

  // Straightforward reference: compare the integers directly.
  function automatic logic refCmp(input logic [2:0] o, input logic s,
                                  input logic [7:0] a, input logic [7:0] b);
    logic lt, eq, r;
    eq = (a == b);
    lt = s ? ($signed(a) < $signed(b)) : (a < b);
    case (o)
      3'd0: r = eq;
      3'd1: r = !eq;
      3'd2: r = lt;
      3'd3: r = lt || eq;
      3'd4: r = !(lt || eq);
      3'd5: r = !lt;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Accept one op on all three builds, then watch 12 edges for each result.
  task automatic applyStimulus(input logic [2:0] o, input logic s,
                               input logic [7:0] a, input logic [7:0] b,
                               output int lat4, output int lat8, output int lat1,
                               output logic r4, output logic r8, output logic r1);
    int waited;
    waited = 0;
    while (!(inReady4 && inReady8 && inReady1) && waited < 20) begin
      @(posedge clock); #1;
      waited++;
    end
    if (waited >= 20) checkOutput("ready_timeout", 0, 1);
    @(negedge clock);
    lhs = a; rhs = b; op = o; is_signed = s; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    lhs = ~a; rhs = a; op = o + 3'd1; is_signed = ~s;
    lat4 = -1; lat8 = -1; lat1 = -1;
    r4 = 1'bx; r8 = 1'bx; r1 = 1'bx;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clock); #1;
      if (lat4 < 0 && outValid4) begin lat4 = k; r4 = res4; end
      if (lat8 < 0 && outValid8) begin lat8 = k; r8 = res8; end
      if (lat1 < 0 && outValid1) begin lat1 = k; r1 = res1; end
    end
    @(negedge clock);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
  endtask

  task automatic doReset();
    @(negedge clock);
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  int   l4, l8, l1;
  logic r4, r8, r1;

  initial begin
    errors = 0; checks = 0;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    lhs = '0; rhs = '0; op = '0; is_signed = 1'b0;

    vecs[0]  = '{3'd2, 1'b1, 8'h80, 8'h7F, 1'b1};
    vecs[1]  = '{3'd2, 1'b0, 8'h80, 8'h7F, 1'b0};
    vecs[2]  = '{3'd4, 1'b1, 8'h7F, 8'h80, 1'b1};
    vecs[3]  = '{3'd5, 1'b0, 8'h7F, 8'h80, 1'b0};
    vecs[4]  = '{3'd0, 1'b0, 8'h5A, 8'h5A, 1'b1};
    vecs[5]  = '{3'd1, 1'b0, 8'h5A, 8'h5A, 1'b0};
    vecs[6]  = '{3'd7, 1'b0, 8'h5A, 8'h5A, 1'b0};
    vecs[7]  = '{3'd2, 1'b0, 8'h00, 8'h01, 1'b1};
    vecs[8]  = '{3'd3, 1'b1, 8'hFF, 8'h00, 1'b1};
    vecs[9]  = '{3'd5, 1'b1, 8'hFF, 8'h00, 1'b0};
    vecs[10] = '{3'd4, 1'b0, 8'hFF, 8'h00, 1'b1};
    vecs[11] = '{3'd1, 1'b0, 8'h12, 8'h13, 1'b1};
    vecs[12] = '{3'd0, 1'b1, 8'h00, 8'h00, 1'b1};
    vecs[13] = '{3'd6, 1'b1, 8'h01, 8'h00, 1'b0};
    vecs[14] = '{3'd3, 1'b0, 8'h03, 8'h03, 1'b1};
    vecs[15] = '{3'd4, 1'b1, 8'h80, 8'h80, 1'b0};

    #12;
    reset_n = 1'b1;
    @(negedge clock);
    checkOutput("reset_in_ready", int'(inReady4), 1);
    checkOutput("reset_out_valid", int'(outValid4), 0);
    checkOutput("reset_res", int'(res4), 0);
`ifdef LUSTRE_SEQ_COMPARE_FLAGS_EN
    checkOutput("reset_flags", int'({flagZ, flagN, flagC, flagV}), 0);
`endif

    for (int i = 0; i < 16; i++) begin
      applyStimulus(vecs[i].op, vecs[i].sgn, vecs[i].a, vecs[i].b, l4, l8, l1, r4, r8, r1);
      checkOutput($sformatf("vec%0d_res_c4", i), int'(r4), int'(vecs[i].exp));
      checkOutput($sformatf("vec%0d_res_c8", i), int'(r8), int'(vecs[i].exp));
      checkOutput($sformatf("vec%0d_res_c1", i), int'(r1), int'(vecs[i].exp));
      checkOutput($sformatf("vec%0d_lat_c4", i), l4, 2);
      checkOutput($sformatf("vec%0d_lat_c8", i), l8, 1);
      checkOutput($sformatf("vec%0d_lat_c1", i), l1, 8);
`ifdef LUSTRE_SEQ_COMPARE_FLAGS_EN
      if (i == 2) checkOutput("flags_overflow_V", int'(flagV), 1);
      if (i == 7) checkOutput("flags_lt_zero_one", int'({flagZ, flagN, flagC, flagV}), 4'b0100);
`endif
    end

    // Backpressure: result held while out_ready is low, then back-to-back accept.
    doReset();
    @(negedge clock);
    lhs = 8'h80; rhs = 8'h7F; op = 3'd2; is_signed = 1'b1; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    checkOutput("bp_first_valid", int'(outValid4), 1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clock); #1;
      checkOutput($sformatf("bp_hold%0d_valid", k), int'(outValid4), 1);
      checkOutput($sformatf("bp_hold%0d_res", k), int'(res4), 1);
      checkOutput($sformatf("bp_hold%0d_in_ready", k), int'(inReady4), 0);
    end
    @(negedge clock);
    lhs = 8'h5A; rhs = 8'h5A; op = 3'd0; is_signed = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    checkOutput("bp_in_ready_on_consume", int'(inReady4), 1);
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    checkOutput("bp_accept_valid_low", int'(outValid4), 0);
    checkOutput("bp_accept_in_ready_low", int'(inReady4), 0);
    repeat (2) @(posedge clock);
    #1;
    checkOutput("bp_second_valid", int'(outValid4), 1);
    checkOutput("bp_second_res", int'(res4), 1);

    // Reset in the middle of a run abandons it immediately.
    doReset();
    @(negedge clock);
    lhs = 8'h10; rhs = 8'h20; op = 3'd2; is_signed = 1'b0; in_valid = 1'b1;
    @(posedge clock); #1;
    in_valid = 1'b0;
    @(posedge clock);
    @(negedge clock);
    reset_n = 1'b0;
    #1;
    checkOutput("midrun_reset_out_valid", int'(outValid4), 0);
    checkOutput("midrun_reset_in_ready", int'(inReady4), 1);
    #1;
    reset_n = 1'b1;
    applyStimulus(3'd3, 1'b0, 8'h03, 8'h03, l4, l8, l1, r4, r8, r1);
    checkOutput("after_reset_le_res", int'(r4), 1);
    checkOutput("after_reset_le_lat", l4, 2);

    // Random sweep across all three chunk widths.
    for (int i = 0; i < 40; i++) begin
      logic [2:0] ro;
      logic       rs;
      logic [7:0] ra, rb;
      logic       e;
      ro = 3'($urandom_range(0, 7));
      rs = 1'($urandom_range(0, 1));
      ra = 8'($urandom);
      rb = (i % 5 == 0) ? ra : 8'($urandom);
      e  = refCmp(ro, rs, ra, rb);
      applyStimulus(ro, rs, ra, rb, l4, l8, l1, r4, r8, r1);
      checkOutput($sformatf("rand%0d_c4 op=%0d s=%0d a=%02h b=%02h", i, ro, rs, ra, rb), int'(r4), int'(e));
      checkOutput($sformatf("rand%0d_c8 op=%0d s=%0d a=%02h b=%02h", i, ro, rs, ra, rb), int'(r8), int'(e));
      checkOutput($sformatf("rand%0d_c1 op=%0d s=%0d a=%02h b=%02h", i, ro, rs, ra, rb), int'(r1), int'(e));
      checkOutput($sformatf("rand%0d_lat_c8", i), l8, 1);
      checkOutput($sformatf("rand%0d_lat_c1", i), l1, 8);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
